multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 8-bit CPU datapath (8-bit PC, 16-bit instr, 8x8 regfile, ALU, data memory).
//  Replaces single-cycle decode: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
//  per-phase write enables so PC, IR, regfile and data memory update only in their own phase.
//  Adds a ready handshake with data memory, a memory timeout fault and a retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a MEM access waits for mem_ready before FAULT (1..255)
//  RET_W        16  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  instr        in   16     instruction word; opcode = instr[15:13]
//  alu_flags    in   4      {N,Z,C,V} from ALU, sampled in EXEC
//  mem_ready    in   1      data memory completes access this cycle
//  ir_we        out  1      latch instr into IR
//  pc_we        out  1      PC write enable
//  pc_src       out  1      0: PC+1, 1: branch target (ALU/mem mux result)
//  reg_src      out  2      regfile address mux selects (as RegSrc)
//  alu_src      out  1      0: register operand, 1: imm = instr[5:0]
//  alu_ctrl     out  2      ALU op
//  reg_we       out  1      regfile write enable
//  mem_re       out  1      data memory read request
//  mem_we       out  1      data memory write request
//  mem_to_reg   out  1      writeback source 1: memory data
//  halted       out  1      core stopped (HALT or FAULT)
//  fault        out  1      memory timeout occurred
//  retired      out  RET_W  instructions completed since reset
// BEHAVIOUR
//  Opcodes: 000 ALU-R (alu_ctrl=instr[1:0]), 001 ALU-I (ADD, alu_src=1), 010 LOAD, 011 STORE,
//   100 BRANCH (cond=instr[12:10]), 111 HALT, 101/110 treated as NOP. Non-R ops use alu_ctrl=2'b00.
//  reset: state=FETCH, all enables 0, halted=0, fault=0, retired=0, wait counter=0.
//  FETCH: ir_we=1, pc_we=1, pc_src=0 -> DECODE. DECODE: outputs decoded, no writes -> EXEC,
//   or HALT if opcode 111.
//  EXEC: ALU-R/ALU-I -> WB; LOAD/STORE -> MEM; BRANCH: pc_we=1,pc_src=1 iff taken, -> FETCH; NOP -> FETCH.
//  Branch cond: 000 always, 001 Z, 010 !Z, 011 N^V, 1xx never. Flags from the same cycle's ALU.
//  MEM: mem_re (LOAD) or mem_we (STORE) held high until mem_ready=1; LOAD -> WB, STORE -> FETCH.
//   Wait counter increments each stalled cycle; reaching MEM_TIMEOUT with mem_ready=0 -> FAULT.
//   mem_ready=1 on the timeout cycle wins (access completes, no fault).
//  WB: reg_we=1, mem_to_reg=1 for LOAD else 0 -> FETCH.
//  retired increments on the last cycle of each instruction (WB, STORE MEM completion, EXEC of
//   BRANCH/NOP); wraps modulo 2^RET_W. HALT counts once on entry.
//  HALT, FAULT: terminal, all enables 0, halted=1 (fault=1 in FAULT); exit only via reset.
//  Latency: ALU 4, LOAD 5+w, STORE 4+w, BRANCH/NOP 3 cycles (w = stall cycles).
//  Async reset mid-access drops mem_re/mem_we immediately; no partial writes issued after.
// CONFIGURATION
//  SINGLE_STEP_EN defined: extra input step (1 bit); FETCH stalls (no ir_we/pc_we) until step=1,
//   executing exactly one instruction per step pulse. Undefined: FETCH proceeds every cycle, no port.
// STRUCTURE
//  Package multicycle_pkg: state_t enum {FETCH,DECODE,EXEC,MEM,WB,HALT,FAULT}, opcode and
//   branch-cond localparams, flag bit indices.
//  Sub-module branch_cond_eval (cond[2:0], flags[3:0] -> taken), combinational.
// TESTING
//  ALU-R 0x0001 after reset -> ir_we@c0, reg_we@c3, retired=1 at c4, alu_ctrl=01 in EXEC.
//  LOAD, mem_ready low 3 cycles -> mem_re high 4 cycles, reg_we+mem_to_reg next cycle, total 8.
//  STORE, mem_ready never -> after 15 stall cycles fault=1, halted=1, mem_we=0 thereafter.
//  BRANCH cond=001 with Z=1 -> pc_we=1,pc_src=1 in EXEC; Z=0 -> pc_we=0, back to FETCH.
//  HALT 0xE000 -> halted=1 after DECODE, retired frozen; reset during MEM -> FETCH, enables 0.
//  SINGLE_STEP_EN: step low 10 cycles -> no ir_we; one step pulse -> exactly one instr retires.

Source files
------------

// File: rtl/multicycle_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
//   Shared types and constants for the multi-cycle CPU sequencer.
//   - state_t      : sequencer phases, including the two terminal states
//   - OP_*         : opcode field values (instr[15:13])
//   - BC_*         : branch condition field values (instr[12:10])
//   - FLAG_*       : bit positions inside the {N,Z,C,V} ALU flag vector
//   - dec_t        : per-instruction datapath mux selects
//   - decode_ctl() : maps opcode/function bits to the datapath selects
// ---------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] OP_ALU_R  = 3'b000;
    localparam logic [2:0] OP_ALU_I  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_NOP5   = 3'b101;
    localparam logic [2:0] OP_NOP6   = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [2:0] BC_ALWAYS = 3'b000;
    localparam logic [2:0] BC_EQ     = 3'b001;
    localparam logic [2:0] BC_NE     = 3'b010;
    localparam logic [2:0] BC_LT     = 3'b011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // reg_src[1]: read Rd as second operand (STORE data source)
    // reg_src[0]: read the PC-relative base (BRANCH target)
    typedef struct packed {
        logic [1:0] reg_src;
        logic       alu_src;
        logic [1:0] alu_ctrl;
    } dec_t;

    // Only ALU-R carries its own ALU op; everything else adds.
    // Every non-R op that uses the ALU takes the 6-bit immediate.
    function automatic dec_t decode_ctl(input logic [2:0] op, input logic [1:0] fn);
        dec_t d;
        d = '0;
        case (op)
            OP_ALU_R:  d.alu_ctrl = fn;
            OP_ALU_I:  d.alu_src  = 1'b1;
            OP_LOAD:   d.alu_src  = 1'b1;
            OP_STORE:  begin d.alu_src = 1'b1; d.reg_src = 2'b10; end
            OP_BRANCH: begin d.alu_src = 1'b1; d.reg_src = 2'b01; end
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
//   Combinational branch decision from the condition field and ALU flags.
//   Ports:
//     cond  [2:0] in   branch condition (instr[12:10])
//     flags [3:0] in   {N,Z,C,V} from the ALU in the same cycle
//     taken       out  1 when the branch must redirect the PC
//   Conditions 1xx are reserved and never taken.
// ---------------------------------------------------------------------------
module branch_cond_eval
    import multicycle_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    // Carry is not consulted by any defined condition.
    logic unused_carry;
    assign unused_carry = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            BC_ALWAYS: taken = 1'b1;
            BC_EQ:     taken = flags[FLAG_Z];
            BC_NE:     taken = ~flags[FLAG_Z];
            BC_LT:     taken = flags[FLAG_N] ^ flags[FLAG_V];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the 8-bit CPU datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; write enables are asserted only
//   in the phase that owns the corresponding state element.
//
//   Optional build macro: SINGLE_STEP_EN adds the 'step' input; FETCH then
//   waits for a step pulse and exactly one instruction runs per pulse.
//
//   Ports:
//     clk, reset        clock (rising edge), async active-high reset
//     step              (SINGLE_STEP_EN only) advance one instruction
//     instr[15:0]       IR contents; stable from DECODE to end of instruction
//     alu_flags[3:0]    {N,Z,C,V}, consulted in EXEC of a branch
//     mem_ready         data memory finishes the current access
//     ir_we, pc_we      IR / PC write enables
//     pc_src            0: PC+1, 1: branch target
//     reg_src, alu_src, alu_ctrl   datapath selects (valid DECODE..WB)
//     reg_we, mem_to_reg           register writeback controls
//     mem_re, mem_we               data memory requests (MEM phase only)
//     halted, fault                terminal status
//     retired[RET_W-1:0]           instructions completed since reset
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [15:0]      instr,
    input  logic [3:0]       alu_flags,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       reg_src,
    output logic             alu_src,
    output logic [1:0]       alu_ctrl,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    // Value of the stall counter on the last MEM cycle that may still
    // complete; a stall in that cycle is the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [7:0]       wait_cnt;
    logic [RET_W-1:0] ret_cnt;
    logic             retire;
    logic             taken;
    logic             go;
    logic [2:0]       op;
    dec_t             dec;

    assign op  = instr[15:13];
    assign dec = decode_ctl(op, instr[1:0]);

    // Operand/immediate fields belong to the datapath, not the sequencer.
    logic unused_fields;
    assign unused_fields = ^instr[9:2];

    branch_cond_eval u_bce (
        .cond  (instr[12:10]),
        .flags (alu_flags),
        .taken (taken)
    );

`ifdef SINGLE_STEP_EN
    // Edge-detect step so a held level runs only one instruction; a pulse
    // that lands mid-instruction is remembered and consumed by the next FETCH.
    logic step_q, step_pend, step_rise;
    assign step_rise = step & ~step_q;
    assign go        = step_rise | step_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (state == FETCH && go)
                step_pend <= 1'b0;
            else if (step_rise)
                step_pend <= 1'b1;
        end
    end
`else
    assign go = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Next state and per-phase outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_src    = 2'b00;
        alu_src    = 1'b0;
        alu_ctrl   = 2'b00;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;

        // Datapath selects follow the IR for the whole body of the instruction.
        if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
            reg_src  = dec.reg_src;
            alu_src  = dec.alu_src;
            alu_ctrl = dec.alu_ctrl;
        end

        case (state)
            FETCH: begin
                if (go) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = DECODE;
                end
            end

            DECODE: begin
                if (op == OP_HALT) begin
                    state_nx = HALT;
                    retire   = 1'b1;
                end else begin
                    state_nx = EXEC;
                end
            end

            EXEC: begin
                case (op)
                    OP_ALU_R, OP_ALU_I: state_nx = WB;
                    OP_LOAD, OP_STORE:  state_nx = MEM;
                    OP_BRANCH: begin
                        pc_we    = taken;
                        pc_src   = taken;
                        state_nx = FETCH;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_nx = FETCH;
                        retire   = 1'b1;
                    end
                endcase
            end

            MEM: begin
                if (op == OP_LOAD) mem_re = 1'b1;
                else               mem_we = 1'b1;
                // Completion beats timeout when both land in the same cycle.
                if (mem_ready) begin
                    if (op == OP_LOAD) begin
                        state_nx = WB;
                    end else begin
                        state_nx = FETCH;
                        retire   = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = FAULT;
                end
            end

            WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (op == OP_LOAD);
                state_nx   = FETCH;
                retire     = 1'b1;
            end

            HALT, FAULT: state_nx = state;

            default: state_nx = FETCH;
        endcase

        // Reset forces state to FETCH asynchronously; keep FETCH's own
        // enables quiet too so nothing is written while reset is held.
        if (reset) begin
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            pc_src = 1'b0;
            reg_we = 1'b0;
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    assign halted  = (state == HALT) || (state == FAULT);
    assign fault   = (state == FAULT);
    assign retired = ret_cnt;

    // -----------------------------------------------------------------------
    // State, stall counter, retired counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            ret_cnt  <= '0;
        end else begin
            state <= state_nx;
            // Counts consecutive stalled MEM cycles; cleared everywhere else
            // so each access starts from zero.
            if (state == MEM && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (retire)
                ret_cnt <= ret_cnt + RET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    // Narrow counter so wrap-around is reachable in a short run.
    localparam int RET_W = 4;
    localparam int TO    = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] instr = '0;
    logic [3:0]  alu_flags = '0;
    logic        mem_ready = 1'b0;
    logic        step = 1'b0;

    logic ir_we, pc_we, pc_src, alu_src, reg_we, mem_re, mem_we, mem_to_reg, halted, fault;
    logic [1:0] reg_src, alu_ctrl;
    logic [RET_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .RET_W(RET_W)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .instr      (instr),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_src    (reg_src),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .reg_we     (reg_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    // Output vector layout (MSB..LSB):
    // ir_we pc_we pc_src reg_src[1:0] alu_src alu_ctrl[1:0] reg_we mem_re mem_we mem_to_reg halted fault
    localparam int B_IR = 13, B_PC = 12, B_PCS = 11, B_AS = 8;
    localparam int B_RW = 5, B_MR = 4, B_MW = 3, B_M2R = 2, B_H = 1, B_F = 0;

    logic [13:0] act, exp_vec = '0;
    logic [RET_W-1:0] exp_ret = '0;
    bit chk_en = 1'b0;
    int checks = 0, errors = 0, cyc = 0, mem_re_cnt = 0;

    assign act = {ir_we, pc_we, pc_src, reg_src, alu_src, alu_ctrl,
                  reg_we, mem_re, mem_we, mem_to_reg, halted, fault};

    // Per-cycle comparison against the model's expectation for this cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_vec) begin
                errors++;
                $display("FAIL ctl_vec cyc %0d: got %b want %b", cyc, act, exp_vec);
            end
            checks++;
            if (retired !== exp_ret) begin
                errors++;
                $display("FAIL retired cyc %0d: got %0d want %0d", cyc, retired, exp_ret);
            end
            if (mem_re) mem_re_cnt++;
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Datapath selects implied by the opcode table.
    function automatic logic [13:0] ctl(input logic [15:0] ins);
        logic [13:0] e;
        e = '0;
        case (ins[15:13])
            3'b000: e[7:6] = ins[1:0];
            3'b001, 3'b010: e[B_AS] = 1'b1;
            3'b011: begin e[B_AS] = 1'b1; e[10:9] = 2'b10; end
            3'b100: begin e[B_AS] = 1'b1; e[10:9] = 2'b01; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit br_taken(input logic [2:0] c, input logic [3:0] f);
        bit n, z, v;
        n = f[3]; z = f[2]; v = f[1 - 1];
        if (c == 3'd0) return 1'b1;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z;
        if (c == 3'd3) return n != v;
        return 1'b0;
    endfunction

    // One clock: drive inputs, publish expectation, advance past the edge.
    task automatic tick(input logic [13:0] e, input logic rdy, input bit ret, input bit stp);
        mem_ready = rdy;
        step      = stp;
        exp_vec   = e;
        chk_en    = 1'b1;
        @(posedge clk); #1;
        if (ret) exp_ret = exp_ret + 1'b1;
        cyc++;
    endtask

    // Expected phase sequence of one instruction from the latency rules;
    // stalls >= TO means the access never completes.
    task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl,
                             input int stalls, output int n);
        logic [2:0]  op;
        logic [13:0] c, e;
        int c0;
        op = ins[15:13];
        c  = ctl(ins);
        c0 = cyc;
        instr = ins;
        alu_flags = fl;
        e = '0; e[B_IR] = 1'b1; e[B_PC] = 1'b1;
        tick(e, 1'b0, 1'b0, 1'b1);
        tick(c, 1'b0, op == 3'b111, 1'b0);
        case (op)
            3'b111: ;
            3'b000, 3'b001: begin
                tick(c, 1'b0, 1'b0, 1'b0);
                e = c; e[B_RW] = 1'b1;
                tick(e, 1'b0, 1'b1, 1'b0);
            end
            3'b010, 3'b011: begin
                tick(c, 1'b0, 1'b0, 1'b0);
                e = c;
                if (op == 3'b010) e[B_MR] = 1'b1; else e[B_MW] = 1'b1;
                for (int i = 0; i < stalls && i < TO; i++) tick(e, 1'b0, 1'b0, 1'b0);
                if (stalls < TO) begin
                    tick(e, 1'b1, op == 3'b011, 1'b0);
                    if (op == 3'b010) begin
                        e = c; e[B_RW] = 1'b1; e[B_M2R] = 1'b1;
                        tick(e, 1'b0, 1'b1, 1'b0);
                    end
                end
            end
            3'b100: begin
                e = c;
                if (br_taken(ins[12:10], fl)) begin e[B_PC] = 1'b1; e[B_PCS] = 1'b1; end
                tick(e, 1'b0, 1'b1, 1'b0);
            end
            default: tick(c, 1'b0, 1'b1, 1'b0);
        endcase
        n = cyc - c0;
    endtask

    // Called just after a rising edge; checks that reset silences everything at once.
    task automatic do_reset();
        chk_en = 1'b0;
        mem_ready = 1'b0;
        step = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_outputs", int'(act), 0);
        chk("rst_retired", int'(retired), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        int n;
        logic [13:0] e;
        #2;
        do_reset();

        // ALU-R ADD-variant with alu_ctrl=01
        run_instr(16'h0001, 4'h0, 0, n);
        chk("lat_alu_r", n, 4);
        chk("retired_first", int'(retired), 1);
        run_instr(16'h2005, 4'h0, 0, n);
        chk("lat_alu_i", n, 4);
        run_instr(16'h0002, 4'h0, 0, n);
        run_instr(16'h0003, 4'h0, 0, n);

        // LOAD with 3 stall cycles
        mem_re_cnt = 0;
        run_instr(16'h4003, 4'h0, 3, n);
        chk("lat_load_w3", n, 8);
        chk("load_mem_re_cycles", mem_re_cnt, 4);
        run_instr(16'h4000, 4'h0, 0, n);
        chk("lat_load_w0", n, 5);
        run_instr(16'h6001, 4'h0, 0, n);
        chk("lat_store_w0", n, 4);
        run_instr(16'h6002, 4'h0, 2, n);
        chk("lat_store_w2", n, 6);
        // ready arrives on the last allowed MEM cycle: completes, no fault
        run_instr(16'h6000, 4'h0, TO - 1, n);
        chk("lat_store_boundary", n, 18);
        chk("boundary_no_fault", int'(fault), 0);

        // Branch conditions
        run_instr(16'h8400, 4'b0100, 0, n);
        chk("lat_branch", n, 3);
        run_instr(16'h8400, 4'b0000, 0, n);
        run_instr(16'h8800, 4'b0000, 0, n);
        run_instr(16'h8800, 4'b0100, 0, n);
        run_instr(16'h8C00, 4'b1000, 0, n);
        run_instr(16'h8C00, 4'b1001, 0, n);
        run_instr(16'h8000, 4'b0000, 0, n);
        run_instr(16'h9000, 4'b0100, 0, n);
        run_instr(16'h9C00, 4'b1111, 0, n);

        // NOP opcodes; 20 instructions total wraps the 4-bit counter
        run_instr(16'hA000, 4'h0, 0, n);
        chk("lat_nop5", n, 3);
        run_instr(16'hC000, 4'h0, 0, n);
        chk("retired_wrap", int'(retired), 4);

`ifdef SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) tick(14'h0000, 1'b0, 1'b0, 1'b0);
        run_instr(16'hA000, 4'h0, 0, n);
        for (int i = 0; i < 5; i++) tick(14'h0000, 1'b0, 1'b0, 1'b0);
        chk("step_one_instr", int'(retired), 5);
`endif

        // Reset while a LOAD is stalled in MEM
        instr = 16'h4000;
        alu_flags = 4'h0;
        e = '0; e[B_IR] = 1'b1; e[B_PC] = 1'b1;
        tick(e, 1'b0, 1'b0, 1'b1);
        tick(ctl(16'h4000), 1'b0, 1'b0, 1'b0);
        tick(ctl(16'h4000), 1'b0, 1'b0, 1'b0);
        e = ctl(16'h4000); e[B_MR] = 1'b1;
        tick(e, 1'b0, 1'b0, 1'b0);
        tick(e, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(16'h6000, 4'h0, 0, n);
        chk("lat_store_after_reset", n, 4);

        // STORE that never completes
        run_instr(16'h6000, 4'h0, 1000, n);
        chk("lat_to_fault", n, 3 + TO);
        e = '0; e[B_H] = 1'b1; e[B_F] = 1'b1;
        for (int i = 0; i < 4; i++) tick(e, 1'b1, 1'b0, 1'b0);
        chk("fault_flag", int'(fault), 1);
        chk("fault_halted", int'(halted), 1);
        do_reset();

        // HALT
        run_instr(16'hE000, 4'h0, 0, n);
        chk("lat_halt", n, 2);
        e = '0; e[B_H] = 1'b1;
        for (int i = 0; i < 5; i++) tick(e, 1'b0, 1'b0, 1'b1);
        chk("halt_flag", int'(halted), 1);
        chk("halt_retired", int'(retired), 1);
        do_reset();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
